// File: rtl/counter_sequencer_pkg.sv
// Shared definitions for the counter sequencer: state encoding and tick-divider sizing.
package counter_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_e;

  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned tick_hz);
    return clk_freq / tick_hz;
  endfunction

  function automatic int unsigned div_width(input int unsigned div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/counter_sequencer_rate_divider.sv
// Free-running modulo-Div cycle counter; tick marks the last cycle of each period.
module rate_divider #(
  parameter int unsigned Div  = 4,
  parameter int unsigned CntW = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic restart,
  output logic tick
);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            at_end;

  assign at_end = (cnt_q == CntW'(Div - 1));
  assign tick   = run && at_end;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = at_end ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Button-driven sequencer issuing enable/clear strobes to an external up-counter at a
// fixed tick rate, with one-shot and wrap-at-limit modes.
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned TICK_HZ  = 10,
  parameter int unsigned WIDTH    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             mode_wrap,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] count_in,
  output logic             cnt_en,
  output logic             cnt_clr_n,
  output logic             running,
  output logic             done,
  output logic [1:0]       state
);

  localparam int unsigned Div  = calc_div(CLK_FREQ, TICK_HZ);
  localparam int unsigned DivW = div_width(Div);

  state_e state_q, state_d;
  logic   start_q, stop_q, clear_q;
  logic   cnt_en_q, cnt_en_d;
  logic   cnt_clr_n_q, cnt_clr_n_d;
  logic   start_ev, stop_ev, clear_ev;
  logic   div_run, div_restart, tick;
  logic   at_limit;

  assign start_ev = start && !start_q;
  assign stop_ev  = stop && !stop_q;
  assign clear_ev = clear && !clear_q;
  assign at_limit = (count_in == limit);

  // Divider advances in every RUN cycle, including the one where stop is seen.
  assign div_run = (state_q == StRun);

  rate_divider #(
    .Div  (Div),
    .CntW (DivW)
  ) u_rate_divider (
    .clock   (clock),
    .reset   (reset),
    .run     (div_run),
    .restart (div_restart),
    .tick    (tick)
  );

  always_comb begin
    state_d     = state_q;
    cnt_en_d    = 1'b0;
    cnt_clr_n_d = 1'b1;
    div_restart = 1'b0;
    if (clear_ev) begin
      state_d     = StIdle;
      cnt_clr_n_d = 1'b0;
      div_restart = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_ev) begin
            state_d     = StRun;
            div_restart = 1'b1;
          end
        end
        StRun: begin
          // One-shot limit compare beats any tick in the same cycle.
          if (!mode_wrap && at_limit) begin
            state_d = StDone;
          end else begin
            if (tick) begin
              if (mode_wrap && at_limit) begin
                cnt_clr_n_d = 1'b0;
              end else begin
                cnt_en_d = 1'b1;
              end
            end
            if (stop_ev) begin
              state_d = StPause;
            end
          end
        end
        StPause: begin
          if (start_ev) begin
            state_d = StRun;
          end
        end
        StDone: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      clear_q     <= 1'b0;
      cnt_en_q    <= 1'b0;
      cnt_clr_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      stop_q      <= stop;
      clear_q     <= clear;
      cnt_en_q    <= cnt_en_d;
      cnt_clr_n_q <= cnt_clr_n_d;
    end
  end

  assign cnt_en    = cnt_en_q;
  assign cnt_clr_n = cnt_clr_n_q;
  assign running   = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign state     = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench: stimulus queues expected strobes (kind + cycle), a negedge monitor
// pops and compares each strobe the sequencer presents to a modelled up-counter.
module tb_counter_sequencer;

  localparam int unsigned W = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic         start, stop, clear, mode_wrap;
  logic [W-1:0] limit;
  logic [W-1:0] count_m = '0;
  logic         cnt_en, cnt_clr_n, running, done;
  logic [1:0]   state;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit is_en;
    int at;
  } exp_t;
  exp_t expq[$];

  always #5 clock = ~clock;

  counter_sequencer #(
    .CLK_FREQ (8),
    .TICK_HZ  (2),
    .WIDTH    (W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .mode_wrap (mode_wrap),
    .limit     (limit),
    .count_in  (count_m),
    .cnt_en    (cnt_en),
    .cnt_clr_n (cnt_clr_n),
    .running   (running),
    .done      (done),
    .state     (state)
  );

  always @(posedge clock) cyc <= cyc + 1;

  // External 16-bit counter with enable and active-low synchronous clear.
  always @(posedge clock) begin
    if (!cnt_clr_n) count_m <= '0;
    else if (cnt_en) count_m <= count_m + 1'b1;
  end

  always @(negedge clock) begin
    exp_t e;
    bit   ok;
    if (!reset && (cnt_en || !cnt_clr_n)) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL strobe: got en=%0b clr_n=%0b at cycle %0d, required no strobe",
                 cnt_en, cnt_clr_n, cyc);
      end else begin
        e  = expq.pop_front();
        ok = (e.at == cyc) && (e.is_en ? (cnt_en && cnt_clr_n) : (!cnt_clr_n && !cnt_en));
        if (!ok) begin
          errors++;
          $display("FAIL strobe: got en=%0b clr_n=%0b at cycle %0d, required %s at cycle %0d",
                   cnt_en, cnt_clr_n, cyc, e.is_en ? "en" : "clr", e.at);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input bit en, input int at);
    exp_t e;
    e.is_en = en;
    e.at    = at;
    expq.push_back(e);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  task automatic drained(input string name);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected strobes missing, required 0", name, expq.size());
      expq.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; mode_wrap = 1'b0; limit = '0;

    // Reset release and idle quiet period
    repeat (3) @(negedge clock);
    #1 reset = 1'b0;
    check("rst_clr_n_low", cnt_clr_n, 0);
    check("rst_state", state, 0);
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    @(posedge clock);
    #1 check("rst_clr_n_high", cnt_clr_n, 1);
    c = cyc;
    wait_cyc(c + 20);
    check("idle_state", state, 0);
    check("idle_count", count_m, 0);
    drained("idle_quiet");

    // One-shot to limit 3
    limit = 3; mode_wrap = 1'b0;
    @(negedge clock); c = cyc; start = 1'b1;
    push(1, c + 5); push(1, c + 9); push(1, c + 13);
    wait_cyc(c + 1);
    check("os_run_state", state, 1);
    check("os_running", running, 1);
    start = 1'b0;
    wait_cyc(c + 14);
    check("os_count3", count_m, 3);
    check("os_still_run", running, 1);
    wait_cyc(c + 15);
    check("os_done_state", state, 3);
    check("os_done", done, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock) start = 1'b1;
      @(negedge clock) start = 1'b0;
    end
    repeat (4) @(negedge clock);
    check("os_done_hold", state, 3);
    check("os_count_hold", count_m, 3);
    drained("oneshot");
    @(negedge clock); c = cyc; clear = 1'b1;
    push(0, c + 1);
    wait_cyc(c + 1);
    check("os_clear_idle", state, 0);
    clear = 1'b0;
    wait_cyc(c + 3);
    check("os_clear_count", count_m, 0);
    drained("oneshot_clear");

    // Pause and resume with held divider
    limit = 100;
    @(negedge clock); c = cyc; start = 1'b1;
    push(1, c + 5); push(1, c + 20); push(0, c + 23);
    wait_cyc(c + 1); start = 1'b0;
    wait_cyc(c + 6); stop = 1'b1;
    wait_cyc(c + 7);
    check("pr_pause_state", state, 2);
    stop = 1'b0;
    wait_cyc(c + 17);
    check("pr_paused_state", state, 2);
    check("pr_paused_count", count_m, 1);
    start = 1'b1;
    wait_cyc(c + 18);
    check("pr_resume_state", state, 1);
    start = 1'b0;
    wait_cyc(c + 22); clear = 1'b1;
    wait_cyc(c + 23);
    check("pr_clear_idle", state, 0);
    clear = 1'b0;
    wait_cyc(c + 26);
    check("pr_count_cleared", count_m, 0);
    drained("pause_resume");

    // Wrap at limit 2, then simultaneous start+clear
    mode_wrap = 1'b1; limit = 2;
    @(negedge clock); c = cyc; start = 1'b1;
    push(1, c + 5); push(1, c + 9); push(0, c + 13); push(1, c + 17); push(0, c + 20);
    wait_cyc(c + 1); start = 1'b0;
    wait_cyc(c + 12);
    check("wr_count2", count_m, 2);
    wait_cyc(c + 15);
    check("wr_wrapped0", count_m, 0);
    check("wr_running", running, 1);
    wait_cyc(c + 19);
    check("wr_count1", count_m, 1);
    start = 1'b1; clear = 1'b1;
    wait_cyc(c + 20);
    check("sim_idle", state, 0);
    start = 1'b0; clear = 1'b0;
    wait_cyc(c + 26);
    check("sim_count", count_m, 0);
    drained("wrap_simul");

    // Asynchronous reset mid-RUN
    mode_wrap = 1'b0; limit = 100;
    @(negedge clock); c = cyc; start = 1'b1;
    wait_cyc(c + 1); start = 1'b0;
    wait_cyc(c + 3);
    check("ar_running_before", running, 1);
    #2 reset = 1'b1;
    #1;
    check("ar_running_drop", running, 0);
    check("ar_state", state, 0);
    check("ar_clr_n", cnt_clr_n, 0);
    check("ar_en", cnt_en, 0);
    @(negedge clock);
    @(negedge clock);
    #1 reset = 1'b0;
    repeat (10) @(negedge clock);
    check("ar_idle_after", state, 0);
    drained("async_reset");

    // Limit 0 one-shot
    limit = 0;
    @(negedge clock); c = cyc; start = 1'b1;
    wait_cyc(c + 1);
    check("l0_run", state, 1);
    start = 1'b0;
    wait_cyc(c + 2);
    check("l0_done_state", state, 3);
    check("l0_done", done, 1);
    wait_cyc(c + 12);
    check("l0_count", count_m, 0);
    drained("limit0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Control FSM that sequences the 16-bit up-counter datapath (enable + active-low synchronous clear) used by the hex-display count labs.
- Turns start/stop/clear button levels into counter enable pulses at a fixed tick rate from the system clock.
- Supports one-shot (stop at limit) and wrap (limit back to 0) modes.
- Sits between the board buttons/switches and the counter; the counter's value is fed back for limit compare.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
TICK_HZ, 10, counter increment rate in Hz; DIV = CLK_FREQ/TICK_HZ, DIV must be >= 2
WIDTH, 16, counter and limit width

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  level, synchronous to clock; rising edge = start/resume
stop  input  1  level; rising edge = pause
clear  input  1  level; rising edge = clear and return to idle
mode_wrap  input  1  0 = one-shot, 1 = wrap at limit
limit  input  WIDTH  terminal count, sampled every cycle
count_in  input  WIDTH  current counter value, fed back from the counter
cnt_en  output  1  one-cycle increment strobe to the counter
cnt_clr_n  output  1  active-low one-cycle synchronous clear to the counter
running  output  1  high in RUN
done  output  1  high in DONE
state  output  2  current state encoding, for debug/LED

Behaviour:
- Edge detect: each of start/stop/clear is registered once; an event is input high while the previous-cycle copy is low. Events are one cycle wide.
- Reset values:
  - state = IDLE; divider = 0; edge registers = 0.
  - cnt_en = 0; cnt_clr_n = 0, so the counter is cleared on the first clock after reset release; cnt_clr_n = 1 from the following cycle.
  - running = 0; done = 0.
- States: IDLE=0, RUN=1, PAUSE=2, DONE=3. All outputs are registered, so there is 1-cycle latency from event to output.
- Event priority within one cycle: clear > stop > start.
- Clear event, any state:
  - Next state IDLE; divider := 0.
  - cnt_clr_n low for exactly one cycle; cnt_en low.
- IDLE:
  - start -> RUN with divider := 0.
  - stop is ignored.
- RUN:
  - Divider counts 0..DIV-1. At divider == DIV-1 a tick fires: divider := 0.
  - On a tick, if mode_wrap = 1 and count_in == limit: pulse cnt_clr_n low one cycle instead of cnt_en (sequence 0..limit,0,...).
  - Otherwise, on a tick: pulse cnt_en high one cycle.
  - One-shot (mode_wrap = 0): if count_in == limit in any RUN cycle -> DONE, with no further cnt_en. Compare has priority over a tick in the same cycle.
  - stop -> PAUSE; divider is held, not reset.
  - start is ignored.
- PAUSE:
  - Divider frozen; no strobes.
  - start -> RUN, resuming the divider from its held value.
- DONE:
  - No strobes; start and stop are ignored; only clear leaves.
- limit = 0 in one-shot with count_in = 0: start -> RUN, then DONE one cycle later with zero increments.
- count_in wrapping past all-ones (limit above the reachable value) is the counter's natural wrap; the sequencer takes no action.
- Asynchronous reset mid-RUN: all state returns to reset values immediately. No strobe is emitted in the reset cycle except cnt_clr_n = 0.

Decomposition:
- Shared package holds:
  - State encoding constants (IDLE/RUN/PAUSE/DONE, 2 bits).
  - The DIV derivation.
  - Divider width as clog2(DIV).
- One sub-module: rate_divider.
  - Ports: clock, reset, run, restart; output tick.
  - Count held when run = 0; restart zeroes the count.
- Edge detection stays inline.

Test Plan:
All scenarios use CLK_FREQ=8, TICK_HZ=2, so DIV=4.
- Reset release: cnt_clr_n = 0 on the first cycle after release, then 1; state=0; cnt_en never high while idle for 20 cycles.
- Count and stop: mode_wrap=0, limit=3, start edge.
  - cnt_en pulses every 4th cycle (count model 1,2,3).
  - DONE is entered the cycle after count_in == 3, with exactly 3 cnt_en pulses.
  - Further start edges do nothing.
- Pause/resume: start, then stop 2 cycles after the first tick, hold 10 cycles, then start.
  - No pulses while paused.
  - The next cnt_en arrives 2 cycles after resume, because the held divider resumes.
- Wrap: mode_wrap=1, limit=2, run 16 cycles -> the counter model sequence is 0,1,2,0,1 via cnt_clr_n low on the tick where count_in == 2.
- Simultaneous events: start and clear edges in the same cycle while in RUN -> IDLE, cnt_clr_n low for one cycle, no cnt_en.
- Edge cases:
  - Async reset asserted mid-RUN between clock edges -> running drops immediately.
  - limit=0 one-shot -> DONE two cycles after the start edge, with zero increments.
